// File: rtl/clk_div_pkg.sv
// Shared types and constants for the programmable clock-divider controller.
package clk_div_pkg;

    localparam int CNT_W_DEF   = 16;
    localparam int BURST_W_DEF = 8;
    localparam int DIV_MIN     = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // ceil(n/2), one bit wider than the operand so n = all-ones cannot wrap.
    function automatic logic [32:0] half_period(input logic [31:0] n);
        return ({1'b0, n} + 33'd1) >> 1;
    endfunction

endpackage

// File: rtl/div_period_counter.sv
// Period counter for the divider: walks cnt through 0..N-1 and produces the
// registered divided clock and tick, both aligned to the counter value.
module div_period_counter
    import clk_div_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_run,
    input  logic             i_run_next,
    input  logic [CNT_W-1:0] i_div,
    input  logic [CNT_W-1:0] i_div_next,
    output logic             o_boundary,
    output logic             o_last_next,
    output logic             o_clk_div,
    output logic             o_tick
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [32:0]      w_half_next;
    logic             r_clk_div;
    logic             r_tick;

    assign o_boundary  = i_run && (r_cnt == (i_div - CNT_W'(1)));
    assign w_half_next = half_period(32'(i_div_next));

    // Next counter value; a period restarts at 0 on entry to a run and after each boundary.
    always_comb begin
        w_cnt_next = {CNT_W{1'b0}};
        if (!i_run_next) begin
            w_cnt_next = {CNT_W{1'b0}};
        end else if (!i_run || o_boundary) begin
            w_cnt_next = {CNT_W{1'b0}};
        end else begin
            w_cnt_next = r_cnt + CNT_W'(1);
        end
    end

    assign o_last_next = i_run_next && (w_cnt_next == (i_div_next - CNT_W'(1)));

    // Counter and registered outputs; O_CLK/tick are computed from the value cnt will hold.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt     <= {CNT_W{1'b0}};
            r_clk_div <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_next;
            r_clk_div <= i_run_next && (33'(w_cnt_next) < w_half_next);
            r_tick    <= i_run_next && (w_cnt_next == {CNT_W{1'b0}});
        end
    end

    assign o_clk_div = r_clk_div;
    assign o_tick    = r_tick;

endmodule

// File: rtl/clk_div_ctrl.sv
// Clock-divider controller: run/drain FSM, configuration handshake with a
// one-deep pending slot applied at period boundaries, and burst counting.
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int BURST_W     = BURST_W_DEF,
    parameter int DEFAULT_DIV = 10
) (
    input  logic               I_CLK,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [CNT_W-1:0]   cfg_div,
    input  logic [BURST_W-1:0] cfg_burst,
    input  logic               start,
    input  logic               stop,
    output logic               O_CLK,
    output logic               tick,
    output logic               busy,
    output logic               done
);

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_active_div;
    logic [CNT_W-1:0]   w_active_div_next;
    logic [CNT_W-1:0]   r_pend_div;
    logic [CNT_W-1:0]   w_cfg_div_clamped;
    logic [BURST_W-1:0] r_active_burst;
    logic [BURST_W-1:0] w_active_burst_next;
    logic [BURST_W-1:0] r_pend_burst;
    logic [BURST_W-1:0] r_burst_cnt;
    logic [BURST_W-1:0] w_burst_cnt_next;
    logic               r_pend_valid;
    logic               w_pend_valid_next;
    logic               w_pend_load;
    logic               r_cfg_ready;
    logic               r_busy;
    logic               r_done;
    logic               w_done_next;
    logic               w_accept;
    logic               w_run;
    logic               w_run_next;
    logic               w_exit;
    logic               w_boundary;
    logic               w_last_next;
    logic               w_final_now;
    logic               w_final_next;

    assign w_accept          = cfg_valid && r_cfg_ready;
    assign w_run             = (r_state != IDLE);
    assign w_run_next        = (w_state_next != IDLE);
    assign w_exit            = w_run && !w_run_next;
    assign w_pend_load       = w_accept && w_run && !w_exit;
    assign w_cfg_div_clamped = (cfg_div < CNT_W'(DIV_MIN)) ? CNT_W'(DIV_MIN) : cfg_div;

    // Burst completes when the period now ending brings the count up to active_burst.
    assign w_final_now  = (r_active_burst != {BURST_W{1'b0}}) &&
                          (({1'b0, r_burst_cnt} + (BURST_W+1)'(1)) >= {1'b0, r_active_burst});
    assign w_final_next = (w_active_burst_next != {BURST_W{1'b0}}) &&
                          (({1'b0, w_burst_cnt_next} + (BURST_W+1)'(1)) >= {1'b0, w_active_burst_next});

    // Next-state logic; a finishing burst takes priority over stop, stop over start.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) w_state_next = RUN;
                else       w_state_next = IDLE;
            end
            RUN: begin
                if (w_boundary && w_final_now) w_state_next = IDLE;
                else if (stop)                 w_state_next = DRAIN;
                else                           w_state_next = RUN;
            end
            DRAIN: begin
                if (w_boundary) w_state_next = IDLE;
                else            w_state_next = DRAIN;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Active configuration: direct load in IDLE, otherwise only at a period boundary.
    always_comb begin
        w_active_div_next   = r_active_div;
        w_active_burst_next = r_active_burst;
        if (!w_run) begin
            if (w_accept) begin
                w_active_div_next   = w_cfg_div_clamped;
                w_active_burst_next = cfg_burst;
            end else begin
                w_active_div_next   = r_active_div;
                w_active_burst_next = r_active_burst;
            end
        end else if (w_boundary && r_pend_valid) begin
            w_active_div_next   = r_pend_div;
            w_active_burst_next = r_pend_burst;
        end else if (w_exit && w_accept) begin
            // Run is ending here, so there is no later boundary to hand a pending value to.
            w_active_div_next   = w_cfg_div_clamped;
            w_active_burst_next = cfg_burst;
        end else begin
            w_active_div_next   = r_active_div;
            w_active_burst_next = r_active_burst;
        end
    end

    // Pending slot occupancy and completed-period count.
    always_comb begin
        w_pend_valid_next = r_pend_valid;
        w_burst_cnt_next  = r_burst_cnt;
        if (w_pend_load)     w_pend_valid_next = 1'b1;
        else if (w_boundary) w_pend_valid_next = 1'b0;
        else                 w_pend_valid_next = r_pend_valid;
        if (!w_run)          w_burst_cnt_next = {BURST_W{1'b0}};
        else if (w_boundary) w_burst_cnt_next = r_burst_cnt + BURST_W'(1);
        else                 w_burst_cnt_next = r_burst_cnt;
    end

    assign w_done_next = w_last_next &&
                         ((w_state_next == DRAIN) || ((w_state_next == RUN) && w_final_next));

    // State register.
    always_ff @(posedge I_CLK) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_next;
    end

    // Configuration, burst count and registered status outputs.
    always_ff @(posedge I_CLK) begin
        if (!rst) begin
            r_active_div   <= CNT_W'(DEFAULT_DIV);
            r_active_burst <= {BURST_W{1'b0}};
            r_pend_valid   <= 1'b0;
            r_pend_div     <= {CNT_W{1'b0}};
            r_pend_burst   <= {BURST_W{1'b0}};
            r_burst_cnt    <= {BURST_W{1'b0}};
            r_cfg_ready    <= 1'b1;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_active_div   <= w_active_div_next;
            r_active_burst <= w_active_burst_next;
            r_pend_valid   <= w_pend_valid_next;
            r_burst_cnt    <= w_burst_cnt_next;
            r_cfg_ready    <= !w_run_next || !w_pend_valid_next;
            r_busy         <= w_run_next;
            r_done         <= w_done_next;
            if (w_pend_load) begin
                r_pend_div   <= w_cfg_div_clamped;
                r_pend_burst <= cfg_burst;
            end else begin
                r_pend_div   <= r_pend_div;
                r_pend_burst <= r_pend_burst;
            end
        end
    end

    div_period_counter #(
        .CNT_W (CNT_W)
    ) u_period (
        .i_clk       (I_CLK),
        .i_rst_n     (rst),
        .i_run       (w_run),
        .i_run_next  (w_run_next),
        .i_div       (r_active_div),
        .i_div_next  (w_active_div_next),
        .o_boundary  (w_boundary),
        .o_last_next (w_last_next),
        .o_clk_div   (O_CLK),
        .o_tick      (tick)
    );

    assign cfg_ready = r_cfg_ready;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: doc/clk_div_ctrl.md
Name: clk_div_ctrl

Overview:
Programmable clock-divider controller that sequences a divided output clock O_CLK from I_CLK. Accepts divide-ratio and burst-length configuration over a valid/ready handshake and applies new ratios only at period boundaries, so O_CLK never glitches. Supports start/stop control, continuous mode, and fixed-length burst mode. Sits between the system control logic and every consumer of the divided clock or tick.

Parameters:
CNT_W, 16, width of divide ratio and period counter
BURST_W, 8, width of burst-length field
DEFAULT_DIV, 10, divide ratio loaded at reset (must be >= 2)

Ports:
I_CLK  in  1  system clock, the only clock
rst  in  1  synchronous reset, active-low
cfg_valid  in  1  configuration offer
cfg_ready  out  1  configuration slot free
cfg_div  in  CNT_W  requested divide ratio N
cfg_burst  in  BURST_W  periods per burst; 0 = continuous
start  in  1  begin generating (sampled in IDLE only)
stop  in  1  finish current period, then halt
O_CLK  out  1  divided clock, registered
tick  out  1  1-cycle pulse on each O_CLK rising edge
busy  out  1  high whenever state != IDLE
done  out  1  1-cycle pulse when burst completes or stop drains

Behaviour:
- Reset (rst==0 at I_CLK edge): state=IDLE, cnt=0, O_CLK=0, tick=0, done=0, busy=0, cfg_ready=1, active_div=DEFAULT_DIV, active_burst=0, pending cleared.
- States: IDLE, RUN, DRAIN.
- Period: cnt runs 0..N-1. O_CLK=1 for cnt < ceil(N/2), else 0. tick=1 when cnt==0. Both are registered and aligned.
- Clamp: an accepted cfg_div < 2 is stored as 2.
- Handshake: transfer when cfg_valid && cfg_ready.
  - In IDLE, cfg_ready=1 and the accepted value goes to active_div/active_burst on the next cycle.
  - In RUN/DRAIN, cfg_ready = !pending_valid. The accepted value is held in pending and moved to active at the boundary (cnt==N-1). The next period uses the new N from its first cycle. pending_valid clears in the same cycle, so cfg_ready returns high on the next cycle.
- IDLE -> RUN: on start. Next cycle cnt=0, O_CLK=1, tick=1. Latency from start sample to O_CLK high is 1 cycle. The burst counter is cleared.
- RUN:
  - At each boundary, completed-period count increments.
  - If active_burst != 0 and count reaches active_burst, go to IDLE: done=1 for that one cycle, and O_CLK=0 on the next cycle.
  - stop asserted: go to DRAIN. stop and start together in RUN: stop wins.
- DRAIN: complete the current period. At the boundary go to IDLE and pulse done. start is ignored in DRAIN. stop in IDLE is ignored.
- Simultaneous boundary + new cfg handshake in RUN: the handshake is blocked if pending is occupied. If pending is empty, the new value is captured into pending and applies at the following boundary, not the current one.
- A burst boundary that coincides with stop completes the burst: single done pulse, go to IDLE.
- Reset mid-operation forces the reset values on the next edge. Pending configuration is discarded.
- Width rules: cnt is CNT_W bits. Compare is against active_div-1. ceil(N/2) = (N+1)>>1, computed in CNT_W+1 bits to avoid overflow at N = 2^CNT_W-1.

Decomposition:
- Package clk_div_pkg holds:
  - state enum {IDLE, RUN, DRAIN}
  - DIV_MIN=2
  - default CNT_W and BURST_W constants
  - helper function for half-period (ceil(N/2))
- One natural sub-module, div_period_counter. It handles cnt, boundary detect, and O_CLK/tick generation for a given active_div and enable. clk_div_ctrl owns the FSM, handshake, pending register, and burst counting.

Test Plan:
- Reset defaults then start, N=10 continuous -> O_CLK 5 high/5 low, tick every 10 cycles, first tick 1 cycle after start, busy=1.
- cfg_div=7 in IDLE, start -> O_CLK 4 high/3 low, period 7; cfg_div=0 accepted -> clamped, period 2 (1 high/1 low).
- N=10 running, cfg_div=4 offered at cnt=3 -> cfg_ready drops next cycle, current period still 10 cycles, following periods 4 cycles, cfg_ready high again after the boundary.
- cfg_div=4, cfg_burst=3, start -> exactly 3 ticks, done pulse on cycle 12 after RUN entry, busy low next cycle, O_CLK=0.
- N=10 running, stop at cnt=2 -> O_CLK completes remaining 7 cycles of period, done pulses at boundary, IDLE; start asserted during DRAIN ignored.
- rst=0 for one cycle at cnt=6 with pending cfg -> next cycle O_CLK=0, busy=0, active_div=10, pending cleared, cfg_ready=1.
